// File: rtl/mem_arbiter.sv
// mem_arbiter: serializes instruction-fetch and data load/store requests onto
// one shared memory port. Data wins contention unless fetch has been passed
// over MAX_WAIT times in a row. Every access is a fixed IDLE->ISSUE->WAIT
// sequence sized for a synchronous-read RAM.
module mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  f_req_i,
    input  logic [DATA_WIDTH-1:0] f_addr_i,
    output logic                  f_gnt_o,
    output logic                  f_rvalid_o,
    input  logic                  d_req_i,
    input  logic                  d_we_i,
    input  logic [DATA_WIDTH-1:0] d_addr_i,
    input  logic [DATA_WIDTH-1:0] d_wdata_i,
    output logic                  d_gnt_o,
    output logic                  d_rvalid_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  busy_o,
    output logic                  mem_we_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    state_t     state_reg, state_next;
    logic [3:0] starve_reg, starve_next;
    logic       owner_reg;      // 1 = current access belongs to the data port
    logic       win_d, win_f;

    // State and starvation counter registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg  <= IDLE;
            starve_reg <= 4'd0;
        end else begin
            state_reg  <= state_next;
            starve_reg <= starve_next;
        end
    end

    // Next-state, arbitration decision and starvation counter update
    always_comb begin
        state_next  = state_reg;
        starve_next = starve_reg;
        win_d       = 1'b0;
        win_f       = 1'b0;
        case (state_reg)
            IDLE: begin
                // Fetch is forced only when it is actually waiting and has
                // been passed over MAX_WAIT consecutive times.
                if (d_req_i && !(f_req_i && (starve_reg == MAX_WAIT_C))) begin
                    win_d = 1'b1;
                end else if (f_req_i) begin
                    win_f = 1'b1;
                end
                if (win_d || win_f) begin
                    state_next = ISSUE;
                end
                if (!f_req_i || win_f) begin
                    starve_next = 4'd0;
                end else if (win_d && (starve_reg != 4'hF)) begin
                    starve_next = starve_reg + 4'd1;
                end
            end
            ISSUE:   state_next = WAIT;
            WAIT:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Registered grant pulses, memory request lines and read-data capture
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            f_gnt_o     <= 1'b0;
            d_gnt_o     <= 1'b0;
            f_rvalid_o  <= 1'b0;
            d_rvalid_o  <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            rdata_o     <= '0;
            owner_reg   <= 1'b0;
        end else begin
            f_gnt_o    <= win_f;
            d_gnt_o    <= win_d;
            f_rvalid_o <= 1'b0;
            d_rvalid_o <= 1'b0;
            // Write enable lives only in ISSUE; it is set on a data win below.
            mem_we_o   <= 1'b0;
            if (win_d) begin
                mem_addr_o  <= d_addr_i;
                mem_wdata_o <= d_wdata_i;
                mem_we_o    <= d_we_i;
                owner_reg   <= 1'b1;
            end else if (win_f) begin
                mem_addr_o  <= f_addr_i;
                owner_reg   <= 1'b0;
            end
            // RAM output is valid during WAIT; writes complete the same way.
            if (state_reg == WAIT) begin
                rdata_o    <= mem_rdata_i;
                d_rvalid_o <= owner_reg;
                f_rvalid_o <= !owner_reg;
            end
        end
    end

    assign busy_o = (state_reg != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a synchronous-read RAM model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        f_req = 1'b0;
    logic [31:0] f_addr = '0;
    logic        f_gnt, f_rvalid;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_gnt, d_rvalid;
    logic [31:0] rdata;
    logic        busy;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;

    int total = 0;
    int bad = 0;

    mem_arbiter #(.DATA_WIDTH(32), .MAX_WAIT(4)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .f_req_i(f_req), .f_addr_i(f_addr), .f_gnt_o(f_gnt), .f_rvalid_o(f_rvalid),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .rdata_o(rdata), .busy_o(busy),
        .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM: read returns old contents; unwritten words read as ~addr
    logic [31:0] mem [logic [31:0]];
    always @(posedge clk) begin
        if (mem.exists(mem_addr)) mem_rdata <= mem[mem_addr];
        else                      mem_rdata <= ~mem_addr;
        if (mem_we) mem[mem_addr] = mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // advance one clock; outputs are then sampled 1 time unit after the edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        mem[32'h0040_0004] = 32'h2009_0005;

        // ---- reset state ----
        #2;
        chk("rst_f_gnt", {31'd0, f_gnt}, 32'd0);
        chk("rst_d_rvalid", {31'd0, d_rvalid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();

        // ---- single fetch ----
        f_req = 1'b1; f_addr = 32'h0040_0004;
        cyc();
        $display("txn fetch addr=%h", f_addr);
        chk("fetch_gnt", {31'd0, f_gnt}, 32'd1);
        chk("fetch_busy", {31'd0, busy}, 32'd1);
        chk("fetch_addr", mem_addr, 32'h0040_0004);
        chk("fetch_we", {31'd0, mem_we}, 32'd0);
        f_req = 1'b0;
        cyc();
        chk("fetch_gnt_gone", {31'd0, f_gnt}, 32'd0);
        chk("fetch_early_rvalid", {31'd0, f_rvalid}, 32'd0);
        cyc();
        chk("fetch_rvalid", {31'd0, f_rvalid}, 32'd1);
        chk("fetch_rdata", rdata, 32'h2009_0005);
        chk("fetch_busy_idle", {31'd0, busy}, 32'd0);
        chk("fetch_no_d_rvalid", {31'd0, d_rvalid}, 32'd0);
        cyc();
        chk("fetch_rvalid_pulse", {31'd0, f_rvalid}, 32'd0);

        // ---- data write then read ----
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1001_0008; d_wdata = 32'hDEAD_BEEF;
        cyc();
        $display("txn write addr=%h data=%h", d_addr, d_wdata);
        chk("wr_gnt", {31'd0, d_gnt}, 32'd1);
        chk("wr_we", {31'd0, mem_we}, 32'd1);
        chk("wr_addr", mem_addr, 32'h1001_0008);
        chk("wr_wdata", mem_wdata, 32'hDEAD_BEEF);
        d_req = 1'b0; d_we = 1'b0;
        cyc();
        chk("wr_we_one_cycle", {31'd0, mem_we}, 32'd0);
        chk("wr_gnt_gone", {31'd0, d_gnt}, 32'd0);
        cyc();
        chk("wr_rvalid", {31'd0, d_rvalid}, 32'd1);
        chk("wr_no_f_rvalid", {31'd0, f_rvalid}, 32'd0);
        cyc();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1001_0008;
        cyc();
        $display("txn read addr=%h", d_addr);
        chk("rd_gnt", {31'd0, d_gnt}, 32'd1);
        chk("rd_we", {31'd0, mem_we}, 32'd0);
        d_req = 1'b0;
        cyc(); cyc();
        chk("rd_rvalid", {31'd0, d_rvalid}, 32'd1);
        chk("rd_rdata", rdata, 32'hDEAD_BEEF);
        cyc();

        // ---- contention: D,D,D,D,F repeating, 3-cycle spacing ----
        f_req = 1'b1; f_addr = 32'h0040_0004;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1001_0008;
        cyc();
        for (int i = 0; i < 10; i++) begin
            logic exp_f;
            exp_f = ((i % 5) == 4);
            $display("txn contention grant %0d: f_gnt=%0b d_gnt=%0b", i, f_gnt, d_gnt);
            chk($sformatf("cont_f_gnt_%0d", i), {31'd0, f_gnt}, {31'd0, exp_f});
            chk($sformatf("cont_d_gnt_%0d", i), {31'd0, d_gnt}, {31'd0, !exp_f});
            cyc(); cyc();
            chk($sformatf("cont_rvalid_%0d", i), {30'd0, f_rvalid, d_rvalid},
                exp_f ? 32'd2 : 32'd1);
            chk($sformatf("cont_rdata_%0d", i), rdata,
                exp_f ? 32'h2009_0005 : 32'hDEAD_BEEF);
            if (i == 9) begin
                f_req = 1'b0; d_req = 1'b0;
            end
            cyc();
        end
        chk("cont_stop_no_gnt", {30'd0, f_gnt, d_gnt}, 32'd0);
        cyc();

        // ---- back-to-back data reads with new address on rvalid cycle ----
        d_req = 1'b1; d_addr = 32'h1000_0100;
        cyc();
        for (int i = 0; i < 3; i++) begin
            logic [31:0] a;
            a = 32'h1000_0100 + 32'(i * 4);
            $display("txn b2b read addr=%h", a);
            chk($sformatf("b2b_gnt_%0d", i), {31'd0, d_gnt}, 32'd1);
            chk($sformatf("b2b_addr_%0d", i), mem_addr, a);
            cyc(); cyc();
            chk($sformatf("b2b_rvalid_%0d", i), {31'd0, d_rvalid}, 32'd1);
            chk($sformatf("b2b_rdata_%0d", i), rdata, ~a);
            d_addr = a + 32'd4;
            if (i == 2) d_req = 1'b0;
            cyc();
        end
        chk("b2b_stop", {31'd0, d_gnt}, 32'd0);
        cyc();

        // ---- starvation counter cleared when fetch drops in IDLE ----
        f_req = 1'b1; d_req = 1'b1; d_addr = 32'h1001_0008;
        cyc();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("stv_d_gnt_%0d", i), {31'd0, d_gnt}, 32'd1);
            if (i == 3) begin
                f_req = 1'b0; d_req = 1'b0;
            end
            cyc(); cyc(); cyc();
        end
        // now IDLE with f_req sampled low once; counter must be 0
        f_req = 1'b1; d_req = 1'b1;
        cyc();
        $display("txn after-drop simultaneous: f_gnt=%0b d_gnt=%0b", f_gnt, d_gnt);
        chk("stv_clear_d_gnt", {31'd0, d_gnt}, 32'd1);
        chk("stv_clear_f_gnt", {31'd0, f_gnt}, 32'd0);
        f_req = 1'b0; d_req = 1'b0;
        cyc(); cyc(); cyc();

        // ---- reset during ISSUE of a write: mem_we drops asynchronously ----
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1001_0010; d_wdata = 32'h1234_5678;
        cyc();
        chk("rstiss_we_before", {31'd0, mem_we}, 32'd1);
        d_req = 1'b0; d_we = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        $display("txn reset during ISSUE");
        chk("rstiss_we", {31'd0, mem_we}, 32'd0);
        chk("rstiss_gnt", {31'd0, d_gnt}, 32'd0);
        chk("rstiss_busy", {31'd0, busy}, 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // ---- reset during WAIT of a write ----
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1001_0014; d_wdata = 32'h0BAD_F00D;
        cyc();
        d_req = 1'b0; d_we = 1'b0;
        cyc();
        chk("rstwait_busy_before", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        $display("txn reset during WAIT");
        chk("rstwait_busy", {31'd0, busy}, 32'd0);
        chk("rstwait_rvalid", {30'd0, f_rvalid, d_rvalid}, 32'd0);
        chk("rstwait_mem_addr", mem_addr, 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("rstwait_no_rvalid", {30'd0, f_rvalid, d_rvalid}, 32'd0);
        chk("rstwait_idle", {31'd0, busy}, 32'd0);
        cyc();
        chk("rstwait_no_rvalid2", {30'd0, f_rvalid, d_rvalid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
